// File: rtl/csi2rx_rgb666_b2p.sv
// ---------------------------------------------------------------------------
// csi2rx_rgb666_b2p
//
// Receive-side RGB666 byte-to-pixel unpacker. Takes the 32-bit payload dwords
// of one CSI-2 long packet (a line) and turns them back into 18-bit pixels,
// one per handshake. It undoes the TX pixel-to-dword packer.
//
// The payload is an LSB-first bitstream:
//   - pixel n sits at stream bits [18n+17:18n];
//   - dword k carries stream bits [32k+31:32k].
//
// Dwords are shifted into an accumulator. Pixels are taken from its bottom
// 18 bits. Two counters track the line:
//   - bits_rem: payload bits not yet emitted as pixels;
//   - dw_rem:   dwords still to be accepted.
//
// Ports
//   clk                   clock
//   rst_n                 asynchronous active-low reset
//   rgb666_convrn_enable  block enable; low forces IDLE and flushes the buffer
//   line_start            one-cycle pulse starting a line; samples line_wc
//   line_wc    [WC_W]     payload byte count of the line
//   dw         [32]       payload dword
//   dw_vld                dword valid
//   dw_rdy                dword accepted when dw_vld && dw_rdy
//   pixel_data [18]       pixel
//   pixel_vld             pixel valid
//   pixel_rdy             pixel consumed when pixel_vld && pixel_rdy
//   pixel_eol             last pixel of the line (qualified by pixel_vld)
//   len_err               one-cycle pulse on a line-length error
// ---------------------------------------------------------------------------
module csi2rx_rgb666_b2p #(
    parameter int BUF_W = 64,
    parameter int WC_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rgb666_convrn_enable,
    input  logic            line_start,
    input  logic [WC_W-1:0] line_wc,
    input  logic [31:0]     dw,
    input  logic            dw_vld,
    output logic            dw_rdy,
    output logic [17:0]     pixel_data,
    output logic            pixel_vld,
    input  logic            pixel_rdy,
    output logic            pixel_eol,
    output logic            len_err
);

    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int BR_W   = WC_W + 3;
    localparam int DR_W   = WC_W - 1;

    localparam logic [FILL_W-1:0] FILL_PIX = FILL_W'(18);
    localparam logic [FILL_W-1:0] FILL_DW  = FILL_W'(32);
    localparam logic [BR_W-1:0]   BITS_PIX = BR_W'(18);
    localparam logic [BR_W-1:0]   BITS_EOL = BR_W'(36);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        TAIL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BUF_W-1:0]  acc;
    logic [BUF_W-1:0]  acc_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [BR_W-1:0]   bits_rem;
    logic [BR_W-1:0]   bits_rem_nxt;
    logic [DR_W-1:0]   dw_rem;
    logic [DR_W-1:0]   dw_rem_nxt;
    logic              len_err_nxt;

    logic              accept;
    logic              pop;
    logic [FILL_W-1:0] fill_pop;
    logic [BUF_W-1:0]  acc_pop;
    logic [DR_W-1:0]   dw_rem_acc;
    logic [BUF_W-1:0]  dw_ext;
    logic [BR_W-1:0]   wc_bits;
    logic [DR_W-1:0]   wc_dwords;

    // Line-length conversions:
    //   - wc_bits:   payload bits in the line;
    //   - wc_dwords: dwords in the line, with the last dword rounded up.
    assign wc_bits   = {line_wc, 3'b000};
    assign wc_dwords = DR_W'(({1'b0, line_wc} + (WC_W + 1)'(3)) >> 2);
    assign dw_ext    = {{(BUF_W - 32){1'b0}}, dw};

    // Output decode.
    // pixel_vld and pixel_eol depend only on registers.
    // dw_rdy also depends on line_start: a restarting line must not swallow
    // a dword that belongs to either the old line or the new line.
    // The fill <= 32 limit leaves room for a whole dword even when no pixel
    // is popped in the same cycle.
    always_comb begin
        dw_rdy     = 1'b0;
        pixel_vld  = 1'b0;
        pixel_eol  = 1'b0;
        pixel_data = acc[17:0];
        case (state)
            ACTIVE: begin
                pixel_vld = (fill >= FILL_PIX) && (bits_rem >= BITS_PIX);
                pixel_eol = pixel_vld && (bits_rem < BITS_EOL);
                dw_rdy    = (dw_rem != '0) && (fill <= FILL_DW) && !line_start;
            end
            TAIL: begin
                dw_rdy = (dw_rem != '0) && !line_start;
            end
            default: begin
                dw_rdy = 1'b0;
            end
        endcase
    end

    assign accept = dw_vld && dw_rdy;
    assign pop    = pixel_vld && pixel_rdy;

    // Pop-then-accept ordering.
    // An outgoing pixel leaves the accumulator first. The incoming dword then
    // lands just above the bits that remain.
    assign fill_pop   = pop ? (fill - FILL_PIX) : fill;
    assign acc_pop    = pop ? (acc >> 18) : acc;
    assign dw_rem_acc = accept ? (dw_rem - DR_W'(1)) : dw_rem;

    // Next-state and datapath update.
    // Priority, highest first:
    //   1. enable low;
    //   2. line_start, which aborts any line in flight;
    //   3. normal per-state behaviour.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        fill_nxt     = fill;
        bits_rem_nxt = bits_rem;
        dw_rem_nxt   = dw_rem;
        len_err_nxt  = 1'b0;

        if (!rgb666_convrn_enable) begin
            state_nxt    = IDLE;
            acc_nxt      = '0;
            fill_nxt     = '0;
            bits_rem_nxt = '0;
            dw_rem_nxt   = '0;
        end else if (line_start) begin
            // A new line inside a running one is an error. The restart still
            // happens in this same cycle.
            if (state != IDLE) begin
                len_err_nxt = 1'b1;
            end
            acc_nxt  = '0;
            fill_nxt = '0;
            if (line_wc == '0) begin
                len_err_nxt  = 1'b1;
                state_nxt    = IDLE;
                bits_rem_nxt = '0;
                dw_rem_nxt   = '0;
            end else begin
                state_nxt    = ACTIVE;
                bits_rem_nxt = wc_bits;
                dw_rem_nxt   = wc_dwords;
            end
        end else begin
            case (state)
                ACTIVE: begin
                    acc_nxt      = acc_pop | (accept ? (dw_ext << fill_pop) : '0);
                    fill_nxt     = fill_pop + (accept ? FILL_DW : '0);
                    bits_rem_nxt = pop ? (bits_rem - BITS_PIX) : bits_rem;
                    dw_rem_nxt   = dw_rem_acc;
                    // The eol pop discards padding and residue bits.
                    // Dwords not yet received are drained in TAIL.
                    // Leftover bits mean line_wc was not a multiple of 9.
                    if (pop && pixel_eol) begin
                        acc_nxt      = '0;
                        fill_nxt     = '0;
                        bits_rem_nxt = '0;
                        state_nxt    = (dw_rem_acc == '0) ? IDLE : TAIL;
                        len_err_nxt  = (bits_rem != BITS_PIX);
                    end
                end
                TAIL: begin
                    dw_rem_nxt = dw_rem_acc;
                    if (dw_rem_acc == '0) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    // len_err is registered, so each error shows as a one-cycle pulse in the
    // cycle after its cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            fill     <= '0;
            bits_rem <= '0;
            dw_rem   <= '0;
            len_err  <= 1'b0;
        end else begin
            acc      <= acc_nxt;
            fill     <= fill_nxt;
            bits_rem <= bits_rem_nxt;
            dw_rem   <= dw_rem_nxt;
            len_err  <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_csi2rx_rgb666_b2p.sv
// ---------------------------------------------------------------------------
// tb_csi2rx_rgb666_b2p
//
// Scoreboard bench for the RGB666 byte-to-pixel unpacker.
//
// Each line is described as a byte array:
//   - random bytes; or
//   - random pixels run through a TX packing model.
//
// Expected pixels come from the stream rule: pixel n is stream bits
// [18n+17:18n]. They are queued for the negedge monitor, which compares them
// against every pixel handshake.
// ---------------------------------------------------------------------------
module tb_csi2rx_rgb666_b2p;

    typedef struct packed {
        logic [17:0] data;
        logic        eol;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        line_start;
    logic [15:0] line_wc;
    logic [31:0] dw;
    logic        dw_vld;
    logic        dw_rdy;
    logic [17:0] pixel_data;
    logic        pixel_vld;
    logic        pixel_rdy;
    logic        pixel_eol;
    logic        len_err;

    exp_t        exp_q[$];
    logic [31:0] dw_q[$];
    logic [7:0]  line_bytes[$];

    int n_checks    = 0;
    int n_pass      = 0;
    int accepted    = 0;
    int pix_seen    = 0;
    int len_err_cnt = 0;
    int len_base    = 0;
    int acc_base    = 0;
    int rdy_mode    = 0;
    bit vld_gaps    = 0;

    csi2rx_rgb666_b2p #(.BUF_W(64), .WC_W(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rgb666_convrn_enable (enable),
        .line_start           (line_start),
        .line_wc              (line_wc),
        .dw                   (dw),
        .dw_vld               (dw_vld),
        .dw_rdy               (dw_rdy),
        .pixel_data           (pixel_data),
        .pixel_vld            (pixel_vld),
        .pixel_rdy            (pixel_rdy),
        .pixel_eol            (pixel_eol),
        .len_err              (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Dword source. It presents the head of dw_q, with optional random
    // valid gaps.
    initial begin
        dw_vld = 1'b0;
        dw     = '0;
        forever begin
            @(posedge clk);
            #2;
            if (dw_q.size() > 0 && (!vld_gaps || $urandom_range(0, 3) != 0)) begin
                dw_vld = 1'b1;
                dw     = dw_q[0];
            end else begin
                dw_vld = 1'b0;
                dw     = $urandom;
            end
        end
    end

    // Pixel sink ready.
    //   mode 0: always ready;
    //   mode 1: random;
    //   mode 2: held low.
    initial begin
        pixel_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       pixel_rdy = 1'b1;
                1:       pixel_rdy = 1'($urandom_range(0, 1));
                default: pixel_rdy = 1'b0;
            endcase
        end
    end

    // Monitor. It samples at the negedge the handshakes that complete on the
    // following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dw_vld && dw_rdy) begin
                accepted++;
                if (dw_q.size() > 0) void'(dw_q.pop_front());
            end
            if (pixel_vld && pixel_rdy) begin
                pix_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected pixel: got 0x%0h eol=%0b, expected none",
                             pixel_data, pixel_eol);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("pixel {eol,data}", {13'd0, pixel_eol, pixel_data},
                                {13'd0, e.eol, e.data});
                end
            end
            if (len_err) len_err_cnt++;
        end
    end

    // Reference model: slice the LSB-first byte stream into 18-bit pixels.
    // The last whole pixel is the eol pixel.
    task automatic expectFromBytes(input int wc);
        int npix;
        npix = (wc * 8) / 18;
        for (int n = 0; n < npix; n++) begin
            exp_t e;
            for (int i = 0; i < 18; i++) begin
                logic [7:0] b;
                b = line_bytes[(18 * n + i) / 8];
                e.data[i] = b[(18 * n + i) % 8];
            end
            e.eol = (n == npix - 1);
            exp_q.push_back(e);
        end
    endtask

    // Queue the line's dwords, then pulse line_start for one cycle.
    task automatic applyStimulus(input int wc, input bit use_model);
        int ndw;
        ndw = (wc + 3) / 4;
        while (line_bytes.size() < ndw * 4) line_bytes.push_back(8'($urandom));
        if (use_model) expectFromBytes(wc);
        @(posedge clk);
        #1;
        dw_q.delete();
        for (int k = 0; k < ndw; k++) begin
            dw_q.push_back({line_bytes[4*k+3], line_bytes[4*k+2],
                            line_bytes[4*k+1], line_bytes[4*k]});
        end
        len_base   = len_err_cnt;
        acc_base   = accepted;
        line_start = 1'b1;
        line_wc    = 16'(wc);
        @(posedge clk);
        #1;
        line_start = 1'b0;
        line_wc    = 16'($urandom);
    endtask

    // Wait for the line to drain, then check:
    //   - the len_err pulse count;
    //   - the number of dwords accepted;
    //   - that the block has gone quiet.
    task automatic finishLine(input string name, input int exp_len, input int exp_dw);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || dw_q.size() != 0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({name, " drained in time"}, 32'(cyc < 3000), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, " len_err pulses"}, 32'(len_err_cnt - len_base), 32'(exp_len));
        checkOutput({name, " dwords accepted"}, 32'(accepted - acc_base), 32'(exp_dw));
        checkOutput({name, " idle {dw_rdy,pixel_vld}"}, {30'd0, dw_rdy, pixel_vld}, 32'd0);
        exp_q.delete();
        dw_q.delete();
        line_bytes.delete();
    endtask

    // Wait, within a cycle budget, until n more pixels have been handed over.
    task automatic waitPixels(input int n);
        int base;
        int cyc;
        base = pix_seen;
        cyc  = 0;
        while (pix_seen - base < n && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("mid-line pixel count", 32'(pix_seen - base), 32'(n));
    endtask

    initial begin
        logic [17:0] pix[16];
        int          wc;
        rst_n      = 1'b0;
        enable     = 1'b1;
        line_start = 1'b0;
        line_wc    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dw_rdy", 32'(dw_rdy), 32'd0);
        checkOutput("reset pixel_vld", 32'(pixel_vld), 32'd0);
        checkOutput("reset pixel_eol", 32'(pixel_eol), 32'd0);
        checkOutput("reset len_err", 32'(len_err), 32'd0);
        checkOutput("reset pixel_data", 32'(pixel_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] directed line_wc=9");
        rdy_mode   = 0;
        line_bytes = '{8'h55, 8'h55, 8'hA9, 8'hAA, 8'h1A, 8'h00, 8'hC0, 8'hFF,
                       8'hFF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back('{18'h15555, 1'b0});
        exp_q.push_back('{18'h2AAAA, 1'b0});
        exp_q.push_back('{18'h00001, 1'b0});
        exp_q.push_back('{18'h3FFFF, 1'b1});
        applyStimulus(9, 1'b0);
        finishLine("wc9 directed", 0, 3);

        $display("[TB] line_wc=36 packed from random pixels, random ready");
        rdy_mode = 1;
        vld_gaps = 1;
        for (int n = 0; n < 16; n++) begin
            pix[n] = 18'($urandom);
            exp_q.push_back('{pix[n], n == 15});
        end
        for (int b = 0; b < 36; b++) line_bytes.push_back(8'd0);
        for (int b = 0; b < 288; b++) begin
            logic [7:0]  tmp;
            logic [17:0] p;
            p        = pix[b / 18];
            tmp      = line_bytes[b / 8];
            tmp[b % 8] = p[b % 18];
            line_bytes[b / 8] = tmp;
        end
        applyStimulus(36, 1'b0);
        finishLine("wc36 packed", 0, 9);

        $display("[TB] residue lines");
        rdy_mode = 0;
        vld_gaps = 0;
        applyStimulus(10, 1'b1);
        finishLine("wc10 residue", 1, 3);
        rdy_mode = 1;
        applyStimulus(14, 1'b1);
        finishLine("wc14 residue", 1, 4);
        applyStimulus(9, 1'b1);
        finishLine("wc9 after residue", 0, 3);

        $display("[TB] random lines");
        vld_gaps = 1;
        for (int i = 0; i < 6; i++) begin
            wc = $urandom_range(3, 40);
            applyStimulus(wc, 1'b1);
            finishLine("random line", (wc % 9 != 0) ? 1 : 0, (wc + 3) / 4);
        end

        $display("[TB] line_start abort");
        rdy_mode = 0;
        vld_gaps = 0;
        applyStimulus(36, 1'b1);
        waitPixels(2);
        rdy_mode = 2;
        exp_q.delete();
        line_bytes.delete();
        applyStimulus(9, 1'b1);
        rdy_mode = 0;
        finishLine("wc9 after abort", 1, 3);

        $display("[TB] enable drop mid-line");
        applyStimulus(36, 1'b1);
        waitPixels(2);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("enable low pixel_vld", 32'(pixel_vld), 32'd0);
        checkOutput("enable low dw_rdy", 32'(dw_rdy), 32'd0);
        exp_q.delete();
        dw_q.delete();
        line_bytes.delete();
        enable = 1'b1;
        applyStimulus(9, 1'b1);
        finishLine("wc9 after enable drop", 0, 3);

        $display("[TB] reset mid-line");
        applyStimulus(36, 1'b1);
        waitPixels(2);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pixel_vld", 32'(pixel_vld), 32'd0);
        checkOutput("async reset dw_rdy", 32'(dw_rdy), 32'd0);
        checkOutput("async reset pixel_data", 32'(pixel_data), 32'd0);
        exp_q.delete();
        dw_q.delete();
        line_bytes.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(9, 1'b1);
        finishLine("wc9 after reset", 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
